// File: rtl/shared_pkg.sv
// Shared constants and types for the APB requester arbiter slice.
package shared_pkg;

    localparam int APB_DATA_WIDTH = 32;
    localparam int APB_ADDR_WIDTH = 32;
    localparam int APB_STRB_WIDTH = APB_DATA_WIDTH / 8;
    localparam int NUM_REQ        = 2;
    localparam int TIMEOUT_CYCLES = 16;

    // Highest register in the completer's map; anything above it is unmapped.
    localparam logic [APB_ADDR_WIDTH-1:0] SYS_CTRL_REG = 32'h0000_003C;
    localparam logic [APB_ADDR_WIDTH-1:0] REG_ADDR_MAX = SYS_CTRL_REG;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'b001,
        ST_SETUP  = 3'b010,
        ST_ACCESS = 3'b100
    } state_e;

endpackage

// File: rtl/apb_rr_arbiter.sv
// Two-way round-robin pick: the requester not granted last wins a tie.
module apb_rr_arbiter (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant,
    output logic       valid
);

    // Pure combinational selection of the winning requester index.
    always_comb begin
        valid = |req;
        grant = 1'b0;
        if (req == 2'b11) begin
            grant = ~last_grant;
        end else if (req[1]) begin
            grant = 1'b1;
        end
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// Arbitrates two requesters onto a single APB master port with address
// screening, a PREADY timeout and registered outputs.
module apb_req_arbiter #(
    parameter int DATA_WIDTH     = shared_pkg::APB_DATA_WIDTH,
    parameter int ADDR_WIDTH     = shared_pkg::APB_ADDR_WIDTH,
    parameter int STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int NUM_REQ        = shared_pkg::NUM_REQ,
    parameter int TIMEOUT_CYCLES = shared_pkg::TIMEOUT_CYCLES
) (
    input  logic                                PCLK,
    input  logic                                PRESET,
    input  logic [NUM_REQ-1:0]                  req,
    input  logic [NUM_REQ-1:0]                  req_write,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_wdata,
    input  logic [NUM_REQ-1:0][STRB_WIDTH-1:0]  req_strb,
    output logic [NUM_REQ-1:0]                  done,
    output logic [DATA_WIDTH-1:0]               rdata,
    output logic                                err,
    output logic                                PSEL,
    output logic                                PENABLE,
    output logic                                PWRITE,
    output logic [ADDR_WIDTH-1:0]               PADDR,
    output logic [DATA_WIDTH-1:0]               PWDATA,
    output logic [STRB_WIDTH-1:0]               PSTRB,
    input  logic [DATA_WIDTH-1:0]               PRDATA,
    input  logic                                PREADY,
    input  logic                                PSLVERR
);

    import shared_pkg::*;

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_e                 state, state_d;
    logic                   gnt, gnt_d;
    logic                   last_grant, last_d;
    logic [CNT_W-1:0]       cnt, cnt_d, cnt_inc;
    logic                   psel_d, penable_d, pwrite_d, err_d;
    logic [ADDR_WIDTH-1:0]  paddr_d;
    logic [DATA_WIDTH-1:0]  pwdata_d, rdata_d;
    logic [STRB_WIDTH-1:0]  pstrb_d;
    logic [NUM_REQ-1:0]     done_d, arb_req;
    logic                   arb_grant, arb_valid, addr_ok;

    // A requester still holds req during its own done cycle; hide it so it
    // is not served twice, while the other requester may be granted at once.
    assign arb_req = req & ~done;
    assign addr_ok = (req_addr[arb_grant][1:0] == 2'b00) &&
                     (req_addr[arb_grant] <= ADDR_WIDTH'(REG_ADDR_MAX));
    assign cnt_inc = cnt + 1'b1;

    apb_rr_arbiter u_rr (
        .req        (arb_req),
        .last_grant (last_grant),
        .grant      (arb_grant),
        .valid      (arb_valid)
    );

    // Next-state and next-output decode for the transfer FSM.
    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        state_d   = state;
        gnt_d     = gnt;
        last_d    = last_grant;
        cnt_d     = cnt;
        psel_d    = PSEL;
        penable_d = PENABLE;
        pwrite_d  = PWRITE;
        paddr_d   = PADDR;
        pwdata_d  = PWDATA;
        pstrb_d   = PSTRB;
        done_d    = '0;
        rdata_d   = rdata;
        err_d     = err;
        case (state)
            ST_IDLE: begin
                if (arb_valid) begin
                    if (addr_ok) begin
                        state_d  = ST_SETUP;
                        gnt_d    = arb_grant;
                        cnt_d    = '0;
                        psel_d   = 1'b1;
                        penable_d = 1'b0;
                        pwrite_d = req_write[arb_grant];
                        paddr_d  = req_addr[arb_grant];
                        pwdata_d = req_wdata[arb_grant];
                        pstrb_d  = req_write[arb_grant] ? req_strb[arb_grant] : '0;
                    end else begin
                        // Unmapped or misaligned: answer locally, never touch the bus.
                        done_d[arb_grant] = 1'b1;
                        err_d   = 1'b1;
                        rdata_d = '0;
                        last_d  = arb_grant;
                    end
                end
            end
            ST_SETUP: begin
                state_d   = ST_ACCESS;
                penable_d = 1'b1;
            end
            ST_ACCESS: begin
                if (!PREADY) begin
                    cnt_d = cnt_inc;
                end
                if (PREADY || (cnt_inc == CNT_W'(TIMEOUT_CYCLES))) begin
                    state_d     = ST_IDLE;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    done_d[gnt] = 1'b1;
                    last_d      = gnt;
                    err_d       = PREADY ? PSLVERR : 1'b1;
                    rdata_d     = (PREADY && !PWRITE) ? PRDATA : '0;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs, cleared asynchronously by PRESET.
    always_ff @(posedge PCLK or posedge PRESET) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (PRESET) begin
            state      <= ST_IDLE;
            gnt        <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= '0;
            PSEL       <= 1'b0;
            PENABLE    <= 1'b0;
            PWRITE     <= 1'b0;
            PADDR      <= '0;
            PWDATA     <= '0;
            PSTRB      <= '0;
            done       <= '0;
            rdata      <= '0;
            err        <= 1'b0;
        end else begin
            state      <= state_d;
            gnt        <= gnt_d;
            last_grant <= last_d;
            cnt        <= cnt_d;
            PSEL       <= psel_d;
            PENABLE    <= penable_d;
            PWRITE     <= pwrite_d;
            PADDR      <= paddr_d;
            PWDATA     <= pwdata_d;
            PSTRB      <= pstrb_d;
            done       <= done_d;
            rdata      <= rdata_d;
            err        <= err_d;
        end
    end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Self-checking bench: a transaction-level schedule model predicts, for each
// round of requests, the service order, bus-visible cycles and responses.
module tb_apb_req_arbiter;

    logic              PCLK = 1'b0;
    logic              PRESET;
    logic [1:0]        req, req_write;
    logic [1:0][31:0]  req_addr, req_wdata;
    logic [1:0][3:0]   req_strb;
    logic [1:0]        done;
    logic [31:0]       rdata;
    logic              err;
    logic              PSEL, PENABLE, PWRITE;
    logic [31:0]       PADDR, PWDATA;
    logic [3:0]        PSTRB;
    logic [31:0]       PRDATA;
    logic              PREADY, PSLVERR;

    int n_checks = 0;
    int n_errors = 0;

    // Completer plan per requester: wait states, read data, slave error.
    int          w_plan [2];
    logic [31:0] prd_plan [2];
    logic        slv_plan [2];
    logic        model_last;

    apb_req_arbiter dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .req       (req),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_strb  (req_strb),
        .done      (done),
        .rdata     (rdata),
        .err       (err),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PSTRB     (PSTRB),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic set_req(input int k, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [3:0] st,
                           input int w, input logic [31:0] prd, input logic slv);
        req_write[k] = wr;
        req_addr[k]  = addr;
        req_wdata[k] = wd;
        req_strb[k]  = st;
        w_plan[k]    = w;
        prd_plan[k]  = prd;
        slv_plan[k]  = slv;
    endtask

    // Raise the requests in 'want' at a negedge (cycle N) and follow the
    // round to its end, checking every cycle against the predicted schedule.
    task automatic run_round(input logic [1:0] want);
        int          order [2];
        int          st [2];
        int          dn [2];
        logic        legal [2];
        logic        e_err [2];
        logic [31:0] e_rdata [2];
        int          n, t0, lat, acc, cur, k;
        logic [1:0]  exp_done;
        logic        exp_psel, exp_pen;

        if (want == 2'b11) begin
            order[0] = model_last ? 0 : 1;
            order[1] = 1 - order[0];
            n = 2;
        end else begin
            order[0] = want[1] ? 1 : 0;
            order[1] = 0;
            n = 1;
        end
        t0 = 0;
        for (int i = 0; i < n; i++) begin
            k = order[i];
            legal[i] = (req_addr[k][1:0] == 2'b00) && (req_addr[k] <= 32'h3C);
            if (!legal[i]) begin
                lat = 1;
                e_err[i] = 1'b1;
                e_rdata[i] = 32'h0;
            end else if (w_plan[k] < 16) begin
                lat = 3 + w_plan[k];
                e_err[i] = slv_plan[k];
                e_rdata[i] = req_write[k] ? 32'h0 : prd_plan[k];
            end else begin
                lat = 18;
                e_err[i] = 1'b1;
                e_rdata[i] = 32'h0;
            end
            st[i] = t0;
            dn[i] = t0 + lat;
            t0 = dn[i];
            model_last = k[0];
        end

        @(negedge PCLK);
        req = want;
        acc = 0;
        PREADY = 1'b0;
        for (int t = 1; t <= dn[n-1] + 1; t++) begin
            @(posedge PCLK);
            @(negedge PCLK);
            exp_done = 2'b00;
            exp_psel = 1'b0;
            exp_pen  = 1'b0;
            cur = -1;
            for (int i = 0; i < n; i++) begin
                if (t == dn[i]) exp_done[order[i]] = 1'b1;
                if (legal[i] && t > st[i] && t < dn[i]) begin
                    exp_psel = 1'b1;
                    cur = i;
                    if (t > st[i] + 1) exp_pen = 1'b1;
                end
            end
            check("done", done, exp_done);
            check("PSEL", PSEL, exp_psel);
            check("PENABLE", PENABLE, exp_pen);
            if (cur >= 0 && t == st[cur] + 1) begin
                k = order[cur];
                check("PADDR", PADDR, req_addr[k]);
                check("PWRITE", PWRITE, req_write[k]);
                check("PSTRB", PSTRB, req_write[k] ? req_strb[k] : 4'h0);
                if (req_write[k]) check("PWDATA", PWDATA, req_wdata[k]);
            end
            for (int i = 0; i < n; i++) begin
                if (t == dn[i]) begin
                    check("err", err, e_err[i]);
                    check("rdata", rdata, e_rdata[i]);
                end
            end
            if (t == dn[n-1] + 1) begin
                check("err_hold", err, e_err[n-1]);
                check("rdata_hold", rdata, e_rdata[n-1]);
            end
            // Requesters release after their predicted done.
            for (int j = 0; j < 2; j++) if (exp_done[j]) req[j] = 1'b0;
            // Completer response for the next edge.
            if (PSEL && PENABLE && cur >= 0) begin
                k = order[cur];
                acc++;
                PREADY  = (acc == w_plan[k] + 1);
                PRDATA  = prd_plan[k];
                PSLVERR = slv_plan[k];
            end else begin
                acc = 0;
                PREADY  = 1'b0;
                PRDATA  = $urandom;
                PSLVERR = 1'($urandom);
            end
        end
        req = 2'b00;
        PREADY = 1'b0;
    endtask

    task automatic rand_req(input int k);
        logic [31:0] a;
        int w;
        if ($urandom_range(0, 3) != 0) begin
            a = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
        end else if ($urandom_range(0, 1) == 1) begin
            a = 32'h40 + ($urandom & 32'h0000_0FFC);
        end else begin
            a = {26'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(1, 3))};
        end
        w = ($urandom_range(0, 7) == 0) ? 16 + $urandom_range(0, 3) : $urandom_range(0, 4);
        set_req(k, 1'($urandom), a, $urandom, 4'($urandom), w, $urandom, 1'($urandom));
    endtask

    initial begin
        logic [1:0] want;
        req = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_strb = '0;
        PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        model_last = 1'b1;
        PRESET = 1'b0;
        #1 PRESET = 1'b1;
        #2;
        check("rst_PSEL", PSEL, 1'b0);
        check("rst_PENABLE", PENABLE, 1'b0);
        check("rst_done", done, 2'b00);
        check("rst_rdata", rdata, 32'h0);
        check("rst_err", err, 1'b0);
        check("rst_PADDR", PADDR, 32'h0);
        check("rst_PSTRB", PSTRB, 4'h0);
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        PRESET = 1'b0;

        // Req0 write, zero wait states.
        set_req(0, 1'b1, 32'h04, 32'hA5A5_A5A5, 4'hF, 0, 32'h0, 1'b0);
        run_round(2'b01);
        // Req1 illegal addresses: above the map, then misaligned.
        set_req(1, 1'b0, 32'h40, 32'h0, 4'h0, 0, 32'h1111_1111, 1'b0);
        run_round(2'b10);
        set_req(1, 1'b0, 32'h06, 32'h0, 4'h0, 0, 32'h2222_2222, 1'b0);
        run_round(2'b10);
        // Simultaneous reads: req0 first, then req1.
        set_req(0, 1'b0, 32'h08, 32'hFFFF_FFFF, 4'hF, 1, 32'hDEAD_BEEF, 1'b0);
        set_req(1, 1'b0, 32'h0C, 32'hFFFF_FFFF, 4'hF, 2, 32'hCAFE_F00D, 1'b0);
        run_round(2'b11);
        // Timeout on a read, then the last in-time PREADY.
        set_req(0, 1'b0, 32'h10, 32'h0, 4'h0, 100, 32'h3333_3333, 1'b0);
        run_round(2'b01);
        set_req(0, 1'b0, 32'h14, 32'h0, 4'h0, 15, 32'h4444_4444, 1'b0);
        run_round(2'b01);
        // Slave error on a write to the top register.
        set_req(1, 1'b1, 32'h3C, 32'h1234_5678, 4'h3, 1, 32'h0, 1'b1);
        run_round(2'b10);

        // Reset in the middle of ACCESS.
        set_req(0, 1'b0, 32'h18, 32'h0, 4'h0, 100, 32'h0, 1'b0);
        @(negedge PCLK);
        req = 2'b01;
        for (int i = 0; i < 6; i++) begin
            @(posedge PCLK);
            @(negedge PCLK);
            if (PENABLE) break;
        end
        check("pre_rst_PENABLE", PENABLE, 1'b1);
        #2 PRESET = 1'b1;
        #1;
        check("mid_rst_PSEL", PSEL, 1'b0);
        check("mid_rst_PENABLE", PENABLE, 1'b0);
        check("mid_rst_done", done, 2'b00);
        req = 2'b00;
        @(negedge PCLK);
        check("mid_rst_done_hold", done, 2'b00);
        PRESET = 1'b0;
        model_last = 1'b1;
        set_req(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, 32'h5555_AAAA, 1'b0);
        set_req(1, 1'b0, 32'h24, 32'h0, 4'h0, 0, 32'hAAAA_5555, 1'b0);
        run_round(2'b11);

        // Randomized rounds.
        for (int r = 0; r < 30; r++) begin
            want = 2'($urandom_range(1, 3));
            rand_req(0);
            rand_req(1);
            run_round(want);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/apb_req_arbiter.md
APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

Interface
REQ-001 The block SHALL take these parameters:
- DATA_WIDTH, 32, data bus width.
- ADDR_WIDTH, 32, address bus width.
- STRB_WIDTH, DATA_WIDTH/8, write-strobe width.
- NUM_REQ, 2, requester count (fixed at 2).
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles without PREADY.

REQ-002 The block SHALL have one clock and an asynchronous, active-high reset. Ports, in this order:
- PCLK  in  1  clock.
- PRESET  in  1  asynchronous active-high reset.
- req  in  NUM_REQ  per-requester transfer request.
- req_write  in  NUM_REQ  1=write, 0=read.
- req_addr  in  NUM_REQ x ADDR_WIDTH  per-requester address.
- req_wdata  in  NUM_REQ x DATA_WIDTH  per-requester write data.
- req_strb  in  NUM_REQ x STRB_WIDTH  per-requester write strobes.
- done  out  NUM_REQ  one-cycle completion pulse.
- rdata  out  DATA_WIDTH  read data, valid with done.
- err  out  1  error flag, valid with done.
- PSEL, PENABLE, PWRITE  out  1  APB master controls.
- PADDR  out  ADDR_WIDTH  APB address.
- PWDATA  out  DATA_WIDTH  APB write data.
- PSTRB  out  STRB_WIDTH  APB write strobes.
- PRDATA  in  DATA_WIDTH  APB read data.
- PREADY, PSLVERR  in  1  APB completer response.

Function
REQ-003 The FSM SHALL use one-hot state_e: ST_IDLE, ST_SETUP, ST_ACCESS. All outputs SHALL be registered.
REQ-004 Requester handshake:
- A requester SHALL hold req and its payload stable until its done pulse.
- A requester MAY re-assert req in the cycle after done.
REQ-005 Arbitration in ST_IDLE:
- Round-robin with a last_grant pointer.
- With both req high, the requester not last granted wins.
- A single requester wins unconditionally.
- The payload SHALL be latched at grant.
REQ-006 Address check at grant: the request is illegal if addr[1:0]!=0 or addr>REG_ADDR_MAX (0x3C). An illegal request SHALL NOT drive PSEL. Instead, done[g]=1, err=1 and rdata=0 SHALL follow in the next cycle, and the FSM SHALL stay in ST_IDLE.
REQ-007 Legal grant in cycle N:
- Cycle N+1: ST_SETUP, PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA set from the latched payload.
- PSTRB SHALL equal the latched strobes for writes and 0 for reads.
REQ-008 ST_SETUP SHALL last exactly one cycle, then move to ST_ACCESS with PENABLE=1 and all address/control/data held stable.
REQ-009 In ST_ACCESS, when PREADY=1 is sampled:
- Next cycle: PSEL=0, PENABLE=0, done[g]=1, err=PSLVERR.
- rdata=PRDATA for reads, 0 for writes.
- The FSM SHALL return to ST_IDLE and last_grant SHALL become g.
- Minimum latency is grant N to done N+3.
REQ-010 Timeout: a counter SHALL clear on ST_SETUP entry and increment on each ST_ACCESS cycle with PREADY=0. On reaching TIMEOUT_CYCLES it SHALL end the transfer as in REQ-009, with err=1 and rdata=0.
REQ-011 done SHALL be one-hot or zero and high for exactly one cycle. rdata and err SHALL hold their values until the next done.
REQ-012 A request arriving while the FSM is not in ST_IDLE SHALL wait. Grants are evaluated only in ST_IDLE, so there is at least one idle cycle between transfers.
REQ-013 A requester dropping req mid-transfer SHALL NOT abort the transfer; done is still pulsed.

Reset
REQ-014 PRESET=1 SHALL immediately (asynchronously) force:
- State ST_IDLE.
- PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB = 0.
- done, rdata, err = 0.
- Timeout counter = 0.
- last_grant = 1, so requester 0 wins first.
REQ-015 Reset asserted mid-transfer SHALL abandon the transfer with no done pulse. After release, arbitration SHALL restart from ST_IDLE.

Structure
REQ-016 shared_pkg SHALL hold NUM_REQ, TIMEOUT_CYCLES, REG_ADDR_MAX (= SYS_CTRL_REG) and state_e. DATA/ADDR/STRB widths SHALL be reused from shared_pkg.
REQ-017 Round-robin selection SHALL be a sub-module, apb_rr_arbiter, that is combinational and takes req and last_grant as inputs and produces a grant index and a valid flag.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Req0 write addr 0x04, wdata 0xA5A5_A5A5, strb 0xF, PREADY=1 in ACCESS -> PSEL at N+1, PENABLE at N+2, done=01 at N+3, err=0.
- Req0 and req1 reads together (0x08, 0x0C) -> req0 served first, then req1. PSTRB=0 for both. rdata equals PRDATA each time.
- Req1 read 0x40, then 0x06 -> no PSEL activity; done=10 and err=1 one cycle after each grant.
- Req0 read with PREADY held 0 -> exactly 16 ACCESS cycles, then done=01, err=1, rdata=0.
- PSLVERR=1 with PREADY on a write to 0x3C -> err=1 with done.
- PRESET during ST_ACCESS -> PSEL and PENABLE drop immediately with no done. The next request from both requesters grants req0.
